// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation actuator stage.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SPLINKER_ON = 2'd1,
        DRIPPER_ON  = 2'd2,
        COOLDOWN    = 2'd3
    } irrigation_state_t;

    localparam int DEFAULT_TICK_DIVIDER  = 1000;
    localparam int DEFAULT_MIN_ON_TICKS  = 30;
    localparam int DEFAULT_MIN_OFF_TICKS = 10;

    // Bits needed to hold the larger of the two tick counts.
    function automatic int timer_width(input int on_ticks, input int off_ticks);
        int largest;
        largest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/irrigation_actuator_sequencer_tick_hold_timer.sv
// Loadable down-counter that decrements on tick and saturates at zero.
module tick_hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // A load wins over a coincident tick so a freshly entered hold is never shortened.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
// Registered actuator stage: minimum on/off hold, splinker/dripper exclusion,
// latched alarm with operator acknowledge, and an independent supply valve.
module irrigation_actuator_sequencer
    import irrigation_pkg::*;
#(
    parameter int TICK_DIVIDER  = DEFAULT_TICK_DIVIDER,
    parameter int MIN_ON_TICKS  = DEFAULT_MIN_ON_TICKS,
    parameter int MIN_OFF_TICKS = DEFAULT_MIN_OFF_TICKS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       supply_request,
    input  logic       splinker_request,
    input  logic       dripper_request,
    input  logic       alarm_request,
    input  logic       alarm_ack,
    output logic       water_supply_valvule,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       alarm,
    output logic [1:0] irrigation_state
);

    localparam int TW = timer_width(MIN_ON_TICKS, MIN_OFF_TICKS);
    localparam int PW = $clog2(TICK_DIVIDER);
    localparam logic [TW-1:0] ON_VALUE  = TW'(MIN_ON_TICKS);
    localparam logic [TW-1:0] OFF_VALUE = TW'(MIN_OFF_TICKS);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIVIDER - 1);

    logic [PW-1:0]     presc_reg;
    logic              tick;
    logic              alarm_reg;
    logic              alarm_next;
    irrigation_state_t state_reg;
    irrigation_state_t state_next;
    logic              splinker_reg;
    logic              dripper_reg;
    logic              supply_reg;
    logic              supply_next;
    logic              irr_load;
    logic [TW-1:0]     irr_load_value;
    logic              irr_zero;
    logic              sup_load;
    logic              sup_zero;

    assign tick = (presc_reg == PRESC_TOP);

    // Prescaler: free-running 0..TICK_DIVIDER-1, tick on the last count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Alarm latch: a live request always dominates an acknowledge.
    always_comb begin
        alarm_next = alarm_reg;
        if (alarm_request) begin
            alarm_next = 1'b1;
        end else if (alarm_ack) begin
            alarm_next = 1'b0;
        end
    end

    // Irrigation next-state: splinker has priority, alarm forces cooldown at once.
    always_comb begin
        state_next     = state_reg;
        irr_load       = 1'b0;
        irr_load_value = ON_VALUE;
        case (state_reg)
            IDLE: begin
                if (!(alarm_reg || alarm_request)) begin
                    if (splinker_request) begin
                        state_next = SPLINKER_ON;
                        irr_load   = 1'b1;
                    end else if (dripper_request) begin
                        state_next = DRIPPER_ON;
                        irr_load   = 1'b1;
                    end
                end
            end
            SPLINKER_ON: begin
                if (alarm_request || (irr_zero && !splinker_request)) begin
                    state_next     = COOLDOWN;
                    irr_load       = 1'b1;
                    irr_load_value = OFF_VALUE;
                end
            end
            DRIPPER_ON: begin
                if (alarm_request ||
                    (irr_zero && (!dripper_request || splinker_request))) begin
                    state_next     = COOLDOWN;
                    irr_load       = 1'b1;
                    irr_load_value = OFF_VALUE;
                end
            end
            COOLDOWN: begin
                if (irr_zero) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Supply valve: opens only with no alarm present, holds for the minimum on time.
    always_comb begin
        supply_next = supply_reg;
        sup_load    = 1'b0;
        if (alarm_request) begin
            supply_next = 1'b0;
        end else if (!supply_reg) begin
            if (supply_request && !alarm_reg) begin
                supply_next = 1'b1;
                sup_load    = 1'b1;
            end
        end else if (sup_zero && !supply_request) begin
            supply_next = 1'b0;
        end
    end

    // Output and state registers; drives are decoded from the next state so they are flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            alarm_reg    <= 1'b0;
            splinker_reg <= 1'b0;
            dripper_reg  <= 1'b0;
            supply_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            alarm_reg    <= alarm_next;
            splinker_reg <= (state_next == SPLINKER_ON);
            dripper_reg  <= (state_next == DRIPPER_ON);
            supply_reg   <= supply_next;
        end
    end

    tick_hold_timer #(.WIDTH(TW)) u_irr_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .load       (irr_load),
        .load_value (irr_load_value),
        .zero       (irr_zero)
    );

    tick_hold_timer #(.WIDTH(TW)) u_supply_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .load       (sup_load),
        .load_value (ON_VALUE),
        .zero       (sup_zero)
    );

    assign water_supply_valvule = supply_reg;
    assign splinker_bomb        = splinker_reg;
    assign dripper_valvule      = dripper_reg;
    assign alarm                = alarm_reg;
    assign irrigation_state     = state_reg;

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// Randomized scoreboard bench: the driver runs a rule-level reference model and
// queues the expected outputs; the monitor pops and compares after every edge.
module tb_irrigation_actuator_sequencer;

    localparam int DIV = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int NUM_CYCLES = 6000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       supply_request = 1'b0;
    logic       splinker_request = 1'b0;
    logic       dripper_request = 1'b0;
    logic       alarm_request = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       water_supply_valvule;
    logic       splinker_bomb;
    logic       dripper_valvule;
    logic       alarm;
    logic [1:0] irrigation_state;

    irrigation_actuator_sequencer #(
        .TICK_DIVIDER  (DIV),
        .MIN_ON_TICKS  (ON),
        .MIN_OFF_TICKS (OFF)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .supply_request       (supply_request),
        .splinker_request     (splinker_request),
        .dripper_request      (dripper_request),
        .alarm_request        (alarm_request),
        .alarm_ack            (alarm_ack),
        .water_supply_valvule (water_supply_valvule),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .alarm                (alarm),
        .irrigation_state     (irrigation_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int  cycle;
        bit  supply;
        bit  splinker;
        bit  dripper;
        bit  alarm;
        int  state;
    } expect_t;

    expect_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    bit driver_done = 0;

    // Reference model: plain integers, mode numbers and tick counts.
    int m_phase;     // cycles since the last tick
    int m_mode;      // 0 idle, 1 splinker, 2 dripper, 3 cooldown
    int m_hold;      // ticks left in the current irrigation phase
    int m_supply_hold;
    bit m_supply;
    bit m_alarm;

    function automatic void model_reset();
        m_phase = 0; m_mode = 0; m_hold = 0; m_supply_hold = 0;
        m_supply = 0; m_alarm = 0;
    endfunction

    function automatic void model_step(bit sup, bit spl, bit drp, bit ar, bit ack);
        bit tk;
        bit new_phase;
        int next_mode;
        bit sup_open;
        tk = (m_phase == DIV - 1);
        next_mode = m_mode;
        new_phase = 0;
        if (m_mode == 0) begin
            if (!m_alarm && !ar && (spl || drp)) begin
                next_mode = spl ? 1 : 2;
                new_phase = 1;
            end
        end else if (m_mode == 3) begin
            if (m_hold == 0) next_mode = 0;
        end else begin
            bit release_ok;
            release_ok = (m_mode == 1) ? !spl : (!drp || spl);
            if (ar || (m_hold == 0 && release_ok)) begin
                next_mode = 3;
                new_phase = 1;
            end
        end
        if (new_phase) m_hold = (next_mode == 3) ? OFF : ON;
        else if (tk && m_hold > 0) m_hold = m_hold - 1;
        m_mode = next_mode;

        sup_open = 0;
        if (ar) m_supply = 0;
        else if (!m_supply) begin
            if (sup && !m_alarm) begin
                m_supply = 1;
                sup_open = 1;
            end
        end else if (m_supply_hold == 0 && !sup) m_supply = 0;
        if (sup_open) m_supply_hold = ON;
        else if (tk && m_supply_hold > 0) m_supply_hold = m_supply_hold - 1;

        if (ar) m_alarm = 1;
        else if (ack) m_alarm = 0;

        m_phase = tk ? 0 : m_phase + 1;
    endfunction

    task automatic check(input string name, input int cyc, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, actual, required);
        end
    endtask

    task automatic check_all_off(input int cyc);
        check("reset_supply",   cyc, int'(water_supply_valvule), 0);
        check("reset_splinker", cyc, int'(splinker_bomb), 0);
        check("reset_dripper",  cyc, int'(dripper_valvule), 0);
        check("reset_alarm",    cyc, int'(alarm), 0);
        check("reset_state",    cyc, int'(irrigation_state), 0);
    endtask

    function automatic bit flip(bit cur, int rise_pm, int fall_pm);
        int r;
        r = int'($urandom_range(999, 0));
        if (cur) return (r < fall_pm) ? 1'b0 : 1'b1;
        return (r < rise_pm) ? 1'b1 : 1'b0;
    endfunction

    // Driver: applies random request levels and queues the model's prediction.
    initial begin
        expect_t e;
        model_reset();
        repeat (3) @(negedge clock);
        check_all_off(-1);
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clock);
            if (cyc > 0 && (cyc % 1500) == 0) begin
                reset_n = 1'b0;
                #1;
                check_all_off(cyc);
                model_reset();
                repeat (3) @(negedge clock);
            end
            reset_n          = 1'b1;
            supply_request   = flip(supply_request, 40, 60);
            splinker_request = flip(splinker_request, 30, 200);
            dripper_request  = flip(dripper_request, 40, 40);
            alarm_request    = flip(alarm_request, 8, 300);
            alarm_ack        = flip(alarm_ack, 100, 300);
            model_step(supply_request, splinker_request, dripper_request,
                       alarm_request, alarm_ack);
            e.cycle    = cyc;
            e.supply   = m_supply;
            e.splinker = (m_mode == 1);
            e.dripper  = (m_mode == 2);
            e.alarm    = m_alarm;
            e.state    = m_mode;
            exp_q.push_back(e);
        end
        driver_done = 1;
    end

    // Monitor: one line per transaction only when it disagrees with the model.
    initial begin
        expect_t e;
        while (!driver_done || exp_q.size() != 0) begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("supply",   e.cycle, int'(water_supply_valvule), int'(e.supply));
                check("splinker", e.cycle, int'(splinker_bomb),        int'(e.splinker));
                check("dripper",  e.cycle, int'(dripper_valvule),      int'(e.dripper));
                check("alarm",    e.cycle, int'(alarm),                int'(e.alarm));
                check("state",    e.cycle, int'(irrigation_state),     e.state);
            end
        end
        check("queue_drained", NUM_CYCLES, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound on simulated time in case a process stalls.
    initial begin
        #(20 * (NUM_CYCLES + 200));
        $display("FAIL timeout: bench did not complete, got %0d vectors", vectors);
        $fatal(1);
    end

endmodule
